// File: rtl/lcd_pkg.sv
// Shared types and constants for the character-LCD bus scheduler.
// Holds the state encoding, the init command ROM and the counter helpers.
package lcd_pkg;

  localparam int unsigned CNT_W    = 16;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned INIT_LEN = 6;

  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_HOME     = 8'h02;
  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT_LOAD,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT,
    ST_IDLE
  } lcd_state_e;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_byte_t;

  // Init sequence: function set x3, display on, clear, entry mode.
  function automatic logic [7:0] init_rom(input logic [IDX_W-1:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: init_rom = CMD_FUNC_SET;
      3'd3:             init_rom = CMD_DISP_ON;
      3'd4:             init_rom = CMD_CLEAR;
      default:          init_rom = CMD_ENTRY;
    endcase
  endfunction

  // Down-counter load value; a zero-cycle parameter still costs one cycle.
  function automatic logic [CNT_W-1:0] cyc_load(input int unsigned p);
    cyc_load = (p == 0) ? '0 : CNT_W'(p - 1);
  endfunction

  // Clear and home commands need the long execution wait.
  function automatic logic is_slow_cmd(input lcd_byte_t b);
    is_slow_cmd = !b.rs && ((b.data == CMD_CLEAR) || (b.data == CMD_HOME) ||
                            (b.data == (CMD_HOME | CMD_CLEAR)));
  endfunction

endpackage

// File: rtl/lcd_rr_arb2.sv
// Two-way round-robin arbiter with a registered one-hot grant.
// The pointer flips to the other requester after every grant.
module lcd_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en_arb,
  output logic [1:0] grant,
  output logic       sel
);

  logic       ptr;
  logic [1:0] pick_c;

  always_comb begin
    pick_c = 2'b00;
    case (req)
      2'b01:   pick_c = 2'b01;
      2'b10:   pick_c = 2'b10;
      2'b11:   pick_c = ptr ? 2'b10 : 2'b01;
      default: pick_c = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant <= 2'b00;
      sel   <= 1'b0;
      ptr   <= 1'b0;
    end else begin
      grant <= en_arb ? pick_c : 2'b00;
      if (en_arb && (pick_c != 2'b00)) begin
        sel <= pick_c[1];
        ptr <= pick_c[0];
      end
    end
  end

endmodule

// File: rtl/lcd_bus_scheduler.sv
// Owns the HD44780 bus: power-up wait, fixed init sequence, then
// round-robin byte transactions from two requesters with strobe timing.
module lcd_bus_scheduler
  import lcd_pkg::*;
#(
  parameter int unsigned PWRUP_CYC = 150,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned EN_CYC    = 2,
  parameter int unsigned HOLD_CYC  = 1,
  parameter int unsigned CMD_WAIT  = 1,
  parameter int unsigned CLR_WAIT  = 16
) (
  input  logic       clk,
  input  logic       rstBt,
  input  logic [1:0] req,
  input  logic       rs_in0,
  input  logic [7:0] data_in0,
  input  logic       rs_in1,
  input  logic [7:0] data_in1,
  output logic [1:0] grant,
  output logic       busy,
  output logic       init_done,
  output logic [7:0] LCD,
  output logic       RS,
  output logic       RW,
  output logic       en
);

  localparam logic [CNT_W-1:0] PWRUP_LD = cyc_load(PWRUP_CYC);
  localparam logic [CNT_W-1:0] SETUP_LD = cyc_load(SETUP_CYC);
  localparam logic [CNT_W-1:0] EN_LD    = cyc_load(EN_CYC);
  localparam logic [CNT_W-1:0] HOLD_LD  = cyc_load(HOLD_CYC);
  localparam logic [CNT_W-1:0] CMD_LD   = cyc_load(CMD_WAIT);
  localparam logic [CNT_W-1:0] CLR_LD   = cyc_load(CLR_WAIT);

  lcd_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  lcd_byte_t        cur, cur_nxt;
  logic             init_done_nxt;
  logic             en_arb;
  logic             sel;

  lcd_rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rstBt),
    .req    (req),
    .en_arb (en_arb),
    .grant  (grant),
    .sel    (sel)
  );

  assign LCD = cur.data;
  assign RS  = cur.rs;
  assign RW  = 1'b0;

  // State, counters, latched byte and strobe registers.
  always_ff @(posedge clk or negedge rstBt) begin
    if (!rstBt) begin
      state     <= ST_PWRUP;
      cnt       <= '0;
      idx       <= '0;
      cur       <= '0;
      init_done <= 1'b0;
      en        <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      cur       <= cur_nxt;
      init_done <= init_done_nxt;
      en        <= (state_nxt == ST_PULSE);
      busy      <= (state_nxt != ST_IDLE);
    end
  end

  // Next-state logic; PWRUP counts up from the reset value, the rest count down.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    idx_nxt       = idx;
    cur_nxt       = cur;
    init_done_nxt = init_done;
    en_arb        = 1'b0;

    case (state)
      ST_PWRUP: begin
        if (cnt == PWRUP_LD) begin
          state_nxt = ST_INIT_LOAD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      ST_INIT_LOAD: begin
        state_nxt    = ST_SETUP;
        cnt_nxt      = SETUP_LD;
        cur_nxt.rs   = 1'b0;
        cur_nxt.data = init_rom(idx);
      end
      ST_SETUP: begin
        if (cnt == '0) begin
          state_nxt = ST_PULSE;
          cnt_nxt   = EN_LD;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      ST_PULSE: begin
        if (cnt == '0) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = HOLD_LD;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      ST_HOLD: begin
        if (cnt == '0) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = is_slow_cmd(cur) ? CLR_LD : CMD_LD;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      ST_WAIT: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 16'd1;
        end else if (init_done) begin
          state_nxt = ST_IDLE;
        end else if (idx == IDX_W'(INIT_LEN - 1)) begin
          state_nxt     = ST_IDLE;
          init_done_nxt = 1'b1;
        end else begin
          state_nxt = ST_INIT_LOAD;
          idx_nxt   = idx + 3'd1;
        end
      end
      ST_IDLE: begin
        // A registered grant marks the latch cycle of the granted byte.
        if (grant != 2'b00) begin
          state_nxt    = ST_SETUP;
          cnt_nxt      = SETUP_LD;
          cur_nxt.rs   = sel ? rs_in1 : rs_in0;
          cur_nxt.data = sel ? data_in1 : data_in0;
        end
      end
      default: begin
        state_nxt = ST_PWRUP;
        cnt_nxt   = '0;
      end
    endcase

    en_arb = (state_nxt == ST_IDLE);
  end

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Directed bench for lcd_bus_scheduler: init sequence timing, arbitration,
// long/short execution waits and asynchronous reset mid-strobe.
module tb_lcd_bus_scheduler;

  logic       clk = 1'b0;
  logic       rstBt;
  logic [1:0] req;
  logic       rs_in0, rs_in1;
  logic [7:0] data_in0, data_in1;
  logic [1:0] grant;
  logic       busy, init_done;
  logic [7:0] LCD;
  logic       RS, RW, en;

  int n_cmp = 0;
  int n_err = 0;
  int viol  = 0;
  int cyc   = 0;

  int         rise_cyc[$];
  logic [8:0] rise_byte[$];
  int         gnt_cyc[$];
  logic [1:0] gnt_val[$];
  logic       en_q = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  lcd_bus_scheduler dut (
    .clk       (clk),
    .rstBt     (rstBt),
    .req       (req),
    .rs_in0    (rs_in0),
    .data_in0  (data_in0),
    .rs_in1    (rs_in1),
    .data_in1  (data_in1),
    .grant     (grant),
    .busy      (busy),
    .init_done (init_done),
    .LCD       (LCD),
    .RS        (RS),
    .RW        (RW),
    .en        (en)
  );

  // Strobe/grant logger and always-on bus invariants.
  always @(negedge clk) begin
    if (en && !en_q) begin
      rise_cyc.push_back(cyc);
      rise_byte.push_back({RS, LCD});
    end
    en_q = en;
    if (grant != 2'b00) begin
      gnt_cyc.push_back(cyc);
      gnt_val.push_back(grant);
    end
    if (RW !== 1'b0 || grant == 2'b11 || (grant != 2'b00 && (busy || !init_done)))
      viol++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic cond(input int s);
    case (s)
      0:       cond = (grant != 2'b00);
      1:       cond = busy;
      2:       cond = !busy;
      3:       cond = init_done;
      default: cond = en;
    endcase
  endfunction

  task automatic wait_for(input int s, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (cond(s)) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) ok = cond(s);
  endtask

  task automatic clear_logs();
    rise_cyc.delete();
    rise_byte.delete();
    gnt_cyc.delete();
    gnt_val.delete();
  endtask

  task automatic check_init(input int base, input string ph);
    logic [8:0] exp_b[6];
    int         exp_gap[5];
    exp_b   = '{9'h038, 9'h038, 9'h038, 9'h00C, 9'h001, 9'h006};
    exp_gap = '{6, 6, 6, 6, 21};
    check({ph, "_strobes"}, rise_cyc.size(), 6);
    if (rise_cyc.size() == 6) begin
      check({ph, "_first_strobe"}, rise_cyc[0] - base, 152);
      for (int i = 0; i < 6; i++)
        check($sformatf("%s_byte%0d", ph, i), 32'(rise_byte[i]), 32'(exp_b[i]));
      for (int i = 0; i < 5; i++)
        check($sformatf("%s_gap%0d", ph, i), rise_cyc[i+1] - rise_cyc[i], exp_gap[i]);
    end
  endtask

  initial begin
    bit ok;
    int base, g;

    rstBt = 1'b1; req = 2'b00;
    rs_in0 = 1'b0; rs_in1 = 1'b0; data_in0 = 8'h00; data_in1 = 8'h00;
    #2 rstBt = 1'b0;
    step(); step();
    check("reset_outputs", 32'({LCD, RS, RW, en, grant, busy, init_done}), 0);

    // Init sequence with no requests.
    clear_logs();
    rstBt = 1'b1;
    base  = cyc;
    step();
    check("busy_after_release", 32'({busy, init_done, en}), 32'b100);
    wait_for(3, 400, ok);
    check("a_init_done_seen", 32'(ok), 1);
    check("a_init_done_cyc", cyc - base, 201);
    check("a_idle_busy", 32'(busy), 0);
    check("a_no_grants", gnt_val.size(), 0);
    check_init(base, "a");

    // Both requesting: strict alternation, 6 clocks per byte.
    clear_logs();
    rs_in0 = 1'b1; data_in0 = 8'h30;
    rs_in1 = 1'b1; data_in1 = 8'h31;
    req = 2'b11;
    for (int i = 0; i < 100 && gnt_val.size() < 4; i++) step();
    req = 2'b00;
    check("rr_grant_count", gnt_val.size(), 4);
    if (gnt_val.size() >= 4) begin
      check("rr_g0", 32'(gnt_val[0]), 1);
      check("rr_g1", 32'(gnt_val[1]), 2);
      check("rr_g2", 32'(gnt_val[2]), 1);
      check("rr_g3", 32'(gnt_val[3]), 2);
      for (int i = 0; i < 3; i++)
        check($sformatf("rr_period%0d", i), gnt_cyc[i+1] - gnt_cyc[i], 6);
    end
    repeat (30) step();
    check("rr_strobes", rise_byte.size(), 4);
    if (rise_byte.size() >= 4) begin
      check("rr_b0", 32'(rise_byte[0]), 32'h130);
      check("rr_b1", 32'(rise_byte[1]), 32'h131);
      check("rr_b2", 32'(rise_byte[2]), 32'h130);
      check("rr_b3", 32'(rise_byte[3]), 32'h131);
    end

    // Requester 1 clear command: long wait; same byte as data: short wait.
    for (int k = 0; k < 2; k++) begin
      rs_in1 = k[0]; data_in1 = 8'h01;
      req = 2'b10;
      wait_for(0, 50, ok);
      check($sformatf("d%0d_grant_seen", k), 32'(ok), 1);
      check($sformatf("d%0d_grant_val", k), 32'(grant), 2);
      g = cyc;
      req = 2'b00;
      wait_for(1, 10, ok);
      wait_for(2, 60, ok);
      check($sformatf("d%0d_idle_seen", k), 32'(ok), 1);
      check($sformatf("d%0d_grant_to_idle", k), cyc - g, (k == 0) ? 21 : 6);
      repeat (3) step();
    end

    // Reset while en is high, requester 0 keeps asking through the re-init.
    rs_in0 = 1'b1; data_in0 = 8'h55;
    req = 2'b01;
    wait_for(4, 50, ok);
    check("e_en_seen", 32'(ok), 1);
    rstBt = 1'b0;
    #1;
    check("e_async_abort", 32'({en, LCD, RS, grant, init_done}), 0);
    step(); step(); step();
    clear_logs();
    rstBt = 1'b1;
    base  = cyc;
    wait_for(3, 400, ok);
    check("e_init_done_seen", 32'(ok), 1);
    check("e_init_done_cyc", cyc - base, 201);
    check_init(base, "e");
    check("e_grant_count", gnt_val.size(), 1);
    if (gnt_val.size() >= 1) begin
      check("e_grant_cyc", gnt_cyc[0] - base, 201);
      check("e_grant_val", 32'(gnt_val[0]), 1);
    end
    req = 2'b00;
    wait_for(4, 20, ok);
    check("e_en_after_grant", cyc - base, 203);
    check("e_bus_byte", 32'({RS, LCD}), 32'h155);
    repeat (10) step();
    check("e_grant_one_cycle", gnt_val.size(), 1);

    check("bus_invariants", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
